// File: rtl/dmem_port_arbiter.sv
// Shares the single-ported data memory between the MEM-stage pipeline (port 0)
// and the loader/debug port (port 1): fixed priority to port 0 with a starvation guard.
module dmem_port_arbiter #(
  parameter int WORD_W     = 64,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic              im_clk,
  input  logic              im_rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [WORD_W-1:0] p0_addr,
  input  logic [WORD_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [WORD_W-1:0] p0_rdata,
  output logic              p0_stall,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [WORD_W-1:0] p1_addr,
  input  logic [WORD_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [WORD_W-1:0] p1_rdata,
  output logic              dm_mem_read,
  output logic              dm_mem_write,
  output logic [WORD_W-1:0] dm_addr,
  output logic [WORD_W-1:0] dm_wdata,
  input  logic [WORD_W-1:0] dm_rdata
);

  localparam logic [CNT_W-1:0] STARVE_CNT = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   starve_cnt;
  logic               owner;
  logic               we_q;
  logic [WORD_W-1:0]  addr_q;
  logic [WORD_W-1:0]  wdata_q;
  logic               p0_gnt_q, p1_gnt_q;
  logic               p0_rv_q, p1_rv_q;
  logic               mem_rd_q, mem_wr_q;

  logic               p0_win;
  logic               sel_we;
  logic [WORD_W-1:0]  sel_addr;
  logic [WORD_W-1:0]  sel_wdata;
  logic               p0_done;

  // Port 1 is forced once it has lost STARVE_MAX consecutive contested decisions.
  always_comb begin
    p0_win    = p0_req & ~(p1_req & (starve_cnt == STARVE_CNT));
    sel_we    = p0_win ? p0_we    : p1_we;
    sel_addr  = p0_win ? p0_addr  : p1_addr;
    sel_wdata = p0_win ? p0_wdata : p1_wdata;
  end

  always_ff @(posedge im_clk or negedge im_rst_n) begin
    if (!im_rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      owner      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      p0_gnt_q   <= 1'b0;
      p1_gnt_q   <= 1'b0;
      p0_rv_q    <= 1'b0;
      p1_rv_q    <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (p0_req | p1_req) begin
            owner    <= ~p0_win;
            we_q     <= sel_we;
            addr_q   <= sel_addr;
            wdata_q  <= sel_wdata;
            p0_gnt_q <= p0_win;
            p1_gnt_q <= ~p0_win;
            mem_wr_q <= sel_we;
            mem_rd_q <= ~sel_we;
            state    <= ACC;
            if (!p0_win)
              starve_cnt <= '0;
            else if (p1_req && starve_cnt != STARVE_CNT)
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        ACC: begin
          p0_gnt_q <= 1'b0;
          p1_gnt_q <= 1'b0;
          mem_wr_q <= 1'b0;
          mem_rd_q <= 1'b0;
          if (we_q) begin
            state <= IDLE;
          end else begin
            p0_rv_q <= ~owner;
            p1_rv_q <= owner;
            state   <= RESP;
          end
        end
        RESP: begin
          p0_rv_q <= 1'b0;
          p1_rv_q <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign p0_gnt       = p0_gnt_q;
  assign p1_gnt       = p1_gnt_q;
  assign p0_rvalid    = p0_rv_q;
  assign p1_rvalid    = p1_rv_q;
  assign p0_rdata     = p0_rv_q ? dm_rdata : '0;
  assign p1_rdata     = p1_rv_q ? dm_rdata : '0;
  assign dm_mem_read  = mem_rd_q;
  assign dm_mem_write = mem_wr_q;
  assign dm_addr      = addr_q;
  assign dm_wdata     = wdata_q;

  // Stall is gated by reset so every output reads 0 while reset is asserted.
  assign p0_done  = (p0_gnt_q & we_q) | p0_rv_q;
  assign p0_stall = im_rst_n & p0_req & ~p0_done;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: directed accesses push expected grant/response
// events; a negedge monitor pops and compares them against what the arbiter presents.
module tb_dmem_port_arbiter;

  logic        im_clk;
  logic        im_rst_n;
  logic        p0_req, p0_we;
  logic [63:0] p0_addr, p0_wdata, p0_rdata;
  logic        p0_gnt, p0_rvalid, p0_stall;
  logic        p1_req, p1_we;
  logic [63:0] p1_addr, p1_wdata, p1_rdata;
  logic        p1_gnt, p1_rvalid;
  logic        dm_mem_read, dm_mem_write;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;

  dmem_port_arbiter #(.WORD_W(64), .STARVE_MAX(4), .CNT_W(3)) dut (
    .im_clk(im_clk), .im_rst_n(im_rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_stall(p0_stall),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .dm_mem_read(dm_mem_read), .dm_mem_write(dm_mem_write),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  initial begin
    im_clk = 1'b0;
    forever #5 im_clk = ~im_clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
    $fatal(1);
  end

  // Data memory model with 1-cycle read latency.
  logic [63:0] mem [logic [63:0]];
  always @(posedge im_clk) begin
    if (dm_mem_write) mem[dm_addr] = dm_wdata;
    if (dm_mem_read) dm_rdata <= mem.exists(dm_addr) ? mem[dm_addr] : 64'h0;
  end

  typedef struct packed {
    logic        rv;
    logic        port;
    logic        we;
    logic        rd;
    logic [63:0] addr;
    logic [63:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=%h req=%h", name, act, req);
    end
  endtask

  function automatic void push_gnt(input logic port, input logic we,
                                   input logic [63:0] addr, input logic [63:0] data);
    ev_t e;
    e.rv = 1'b0; e.port = port; e.we = we; e.rd = ~we;
    e.addr = addr; e.data = we ? data : 64'h0;
    exp_q.push_back(e);
  endfunction

  function automatic void push_rv(input logic port, input logic [63:0] data);
    ev_t e;
    e.rv = 1'b1; e.port = port; e.we = 1'b0; e.rd = 1'b0;
    e.addr = 64'h0; e.data = data;
    exp_q.push_back(e);
  endfunction

  // Monitor: compare each grant/response the arbiter presents against the scoreboard.
  always @(negedge im_clk) begin
    if (im_rst_n) begin
      ev_t act, req;
      checks++;
      if ((dm_mem_read | dm_mem_write) !== (p0_gnt | p1_gnt) || (p0_gnt & p1_gnt)) begin
        errors++;
        $display("FAIL strobe_gnt: act rd=%b wr=%b g0=%b g1=%b req one strobe per single grant",
                 dm_mem_read, dm_mem_write, p0_gnt, p1_gnt);
      end
      if (p0_gnt | p1_gnt | p0_rvalid | p1_rvalid) begin
        if (p0_gnt | p1_gnt) begin
          act.rv = 1'b0; act.port = p1_gnt; act.we = dm_mem_write; act.rd = dm_mem_read;
          act.addr = dm_addr; act.data = dm_mem_write ? dm_wdata : 64'h0;
        end else begin
          act.rv = 1'b1; act.port = p1_rvalid; act.we = 1'b0; act.rd = 1'b0;
          act.addr = 64'h0; act.data = p1_rvalid ? p1_rdata : p0_rdata;
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: act rv=%b port=%b addr=%h data=%h req=none",
                   act.rv, act.port, act.addr, act.data);
        end else begin
          req = exp_q.pop_front();
          if (act !== req) begin
            errors++;
            $display("FAIL sb_event: act rv=%b port=%b we=%b rd=%b addr=%h data=%h req rv=%b port=%b we=%b rd=%b addr=%h data=%h",
                     act.rv, act.port, act.we, act.rd, act.addr, act.data,
                     req.rv, req.port, req.we, req.rd, req.addr, req.data);
          end
        end
      end
    end
  end

  task automatic drive(input int p, input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    if (p == 0) begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
  endtask

  // Waits for the done cycle of port p, then steps just past the done edge.
  task automatic wait_done(input int p, input logic we);
    logic done;
    done = 1'b0;
    for (int unsigned k = 0; k < 40 && !done; k++) begin
      @(negedge im_clk);
      if (p == 0) done = we ? (p0_gnt & dm_mem_write) : p0_rvalid;
      else        done = we ? (p1_gnt & dm_mem_write) : p1_rvalid;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout port%0d: act=no done req=done within 40 cycles", p);
    end
    @(posedge im_clk);
    #1;
  endtask

  task automatic run_port(input int p, input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      drive(p, 1'b1, base + 64'(8 * i), (base + 64'(8 * i)) ^ 64'h5A5A);
      wait_done(p, 1'b1);
    end
    if (p == 0) p0_req = 1'b0;
    else        p1_req = 1'b0;
  endtask

  task automatic push_contest(input int n0, input logic [63:0] b0, input logic [63:0] b1,
                              input int len, input logic [9:0] order);
    int i0, i1;
    logic [63:0] a;
    i0 = 0; i1 = 0;
    for (int k = 0; k < len; k++) begin
      if (order[k]) begin
        a = b1 + 64'(8 * i1); i1++;
        push_gnt(1'b1, 1'b1, a, a ^ 64'h5A5A);
      end else begin
        a = b0 + 64'(8 * i0); i0++;
        push_gnt(1'b0, 1'b1, a, a ^ 64'h5A5A);
      end
    end
    if (i0 != n0) $display("note: contest table covers %0d port-0 accesses", i0);
  endtask

  function automatic logic [63:0] quiet_vec();
    return {57'h0, p0_gnt, p0_rvalid, p0_stall, p1_gnt, p1_rvalid, dm_mem_read, dm_mem_write};
  endfunction

  initial begin
    im_rst_n = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    dm_rdata = '0;

    // Reset state
    repeat (2) @(negedge im_clk);
    chk("reset_quiet", quiet_vec(), 64'h0);
    chk("reset_addr", dm_addr, 64'h0);
    im_rst_n = 1'b1;

    // 1: port-0 write of 0xDEAD to 0x10
    @(posedge im_clk); #1;
    drive(0, 1'b1, 64'h10, 64'hDEAD);
    push_gnt(1'b0, 1'b1, 64'h10, 64'hDEAD);
    @(negedge im_clk);
    chk("t1_idle_stall", p0_stall, 1);
    chk("t1_idle_nowrite", dm_mem_write, 0);
    @(negedge im_clk);
    chk("t1_acc_write", dm_mem_write, 1);
    chk("t1_acc_gnt", p0_gnt, 1);
    chk("t1_acc_addr", dm_addr, 64'h10);
    chk("t1_acc_stall", p0_stall, 0);
    @(posedge im_clk); #1;
    p0_req = 1'b0;
    @(negedge im_clk);
    chk("t1_back_idle", quiet_vec(), 64'h0);

    // 2: port-0 read of 0x10
    @(posedge im_clk); #1;
    drive(0, 1'b0, 64'h10, 64'h0);
    push_gnt(1'b0, 1'b0, 64'h10, 64'h0);
    push_rv(1'b0, 64'hDEAD);
    @(negedge im_clk);
    chk("t2_idle_stall", p0_stall, 1);
    @(negedge im_clk);
    chk("t2_acc_gnt", p0_gnt, 1);
    chk("t2_acc_read", dm_mem_read, 1);
    chk("t2_acc_stall", p0_stall, 1);
    @(negedge im_clk);
    chk("t2_resp_rvalid", p0_rvalid, 1);
    chk("t2_resp_rdata", p0_rdata, 64'hDEAD);
    chk("t2_resp_stall", p0_stall, 0);
    @(posedge im_clk); #1;
    p0_req = 1'b0;

    // 3: both ports contending; grant order 0,0,0,0,1,0,0,0,0,1 (bit k = winner of access k)
    @(posedge im_clk); #1;
    push_contest(8, 64'h100, 64'h200, 10, 10'b10_0001_0000);
    fork
      run_port(0, 8, 64'h100);
      run_port(1, 2, 64'h200);
    join

    // 4: port-1 read; p0_req rises during its RESP and must wait
    @(posedge im_clk); #1;
    drive(1, 1'b0, 64'h200, 64'h0);
    push_gnt(1'b1, 1'b0, 64'h200, 64'h0);
    push_rv(1'b1, 64'h200 ^ 64'h5A5A);
    push_gnt(1'b0, 1'b0, 64'h10, 64'h0);
    push_rv(1'b0, 64'hDEAD);
    @(posedge im_clk); #1;
    @(posedge im_clk); #1;
    drive(0, 1'b0, 64'h10, 64'h0);
    @(negedge im_clk);
    chk("t4_resp_p1_rvalid", p1_rvalid, 1);
    chk("t4_resp_no_strobe", {dm_mem_read, dm_mem_write, p0_gnt}, 0);
    @(posedge im_clk); #1;
    p1_req = 1'b0;
    @(negedge im_clk);
    chk("t4_idle_no_gnt", {dm_mem_read, dm_mem_write, p0_gnt, p1_rvalid}, 0);
    chk("t4_idle_stall", p0_stall, 1);
    @(negedge im_clk);
    chk("t4_p0_gnt", p0_gnt, 1);
    wait_done(0, 1'b0);
    p0_req = 1'b0;

    // 5: reset during ACC of a contested write; starvation count must restart from 0
    @(posedge im_clk); #1;
    drive(0, 1'b1, 64'h300, 64'h300 ^ 64'h5A5A);
    drive(1, 1'b1, 64'h400, 64'h400 ^ 64'h5A5A);
    @(posedge im_clk); #1;
    chk("t5_acc_write", dm_mem_write, 1);
    #1;
    im_rst_n = 1'b0;
    #1;
    chk("t5_reset_quiet", quiet_vec(), 64'h0);
    chk("t5_reset_addr", dm_addr, 64'h0);
    @(negedge im_clk);
    @(negedge im_clk);
    chk("t5_reset_held", quiet_vec(), 64'h0);
    push_contest(4, 64'h300, 64'h400, 5, 10'b00_0001_0000);
    im_rst_n = 1'b1;
    fork
      run_port(0, 4, 64'h300);
      run_port(1, 1, 64'h400);
    join

    // 6: no requests for 10 cycles
    for (int unsigned c = 0; c < 10; c++) begin
      @(negedge im_clk);
      chk("t6_idle_quiet", quiet_vec(), 64'h0);
    end
    chk("t6_addr_hold", dm_addr, 64'h400);

    chk("sb_drained", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
